// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Common-data-bus arbiter for an out-of-order core. Each functional unit (FU)
// hands its completed result to the arbiter through a valid/ready handshake.
// The arbiter keeps one holding slot per FU. Every cycle it picks one FU,
// either from its slot or straight from its input, and places that result on
// a registered CDB broadcast.
//
// Arbitration:
//   default          fixed priority, lowest FU index wins
//   CDB_RR_EN        round-robin. The search starts at a pointer, and the
//                    pointer moves to (winner + 1) mod NUM_FU after each grant
//
// Ports:
//   clk        in   single clock, all state changes on its rising edge
//   reset_n    in   asynchronous active-low reset
//   flush      in   synchronous squash; drops every held and broadcast result
//   fu_valid   in   [NUM_FU]           FU i offers a result
//   fu_tag     in   [NUM_FU][TAG_W]    ROB tag of each offered result
//   fu_value   in   [NUM_FU][DATA_W]   value of each offered result
//   fu_ready   out  [NUM_FU]           FU i's offer is taken this cycle
//   cdb_valid  out  broadcast valid
//   cdb_tag    out  broadcast ROB tag
//   cdb_value  out  broadcast value
//   cdb_fu     out  index of the FU that owns the broadcast
// ---------------------------------------------------------------------------

`ifndef XLEN
`define XLEN 32
`endif

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int DATA_W = `XLEN,
  parameter int TAG_W  = `ROB_TAG_LEN,
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_value,
  output logic [NUM_FU-1:0]              fu_ready,
  output logic                           cdb_valid,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [DATA_W-1:0]              cdb_value,
  output logic [FU_W-1:0]                cdb_fu
);

  logic [NUM_FU-1:0]              slot_valid;
  logic [NUM_FU-1:0][TAG_W-1:0]   slot_tag;
  logic [NUM_FU-1:0][DATA_W-1:0]  slot_value;

  logic [NUM_FU-1:0]              request;
  logic [NUM_FU-1:0]              grant;
  logic                           grant_any;
  logic [FU_W-1:0]                grant_idx;
  logic [TAG_W-1:0]               sel_tag;
  logic [DATA_W-1:0]              sel_value;

  // An FU competes for the bus if its slot holds a result or if it offers one
  // right now. An empty slot can pass its incoming result straight to the
  // CDB register. This keeps uncontended latency at one cycle. The request
  // does not depend on fu_ready, so no combinational loop forms.
  assign request = slot_valid | fu_valid;

`ifdef CDB_RR_EN
  logic [FU_W-1:0] rr_ptr;
  int              rr_idx;
  logic [FU_W-1:0] rr_sel;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    rr_sel    = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= NUM_FU) rr_idx = rr_idx - NUM_FU;
      rr_sel = FU_W'(rr_idx);
      if (!grant_any && request[rr_sel]) begin
        grant_any = 1'b1;
        grant_idx = rr_sel;
      end
    end
    if (flush) grant_any = 1'b0;
  end

  // The pointer advances only on a real grant, so it stays put during
  // flush and idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == FU_W'(NUM_FU - 1)) ? '0 : grant_idx + FU_W'(1);
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!grant_any && request[FU_W'(k)]) begin
        grant_any = 1'b1;
        grant_idx = FU_W'(k);
      end
    end
    if (flush) grant_any = 1'b0;
  end
`endif

  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // A granted slot empties at this edge, so it can take a new result in the
  // same cycle. Reset and flush block acceptance so nothing slips in.
  assign fu_ready = (~slot_valid | grant) & {NUM_FU{reset_n & ~flush}};

  // The winner's result comes from its slot when the slot is occupied.
  // Otherwise it comes directly from the FU input (bypass).
  always_comb begin
    if (slot_valid[grant_idx]) begin
      sel_tag   = slot_tag[grant_idx];
      sel_value = slot_value[grant_idx];
    end else begin
      sel_tag   = fu_tag[grant_idx];
      sel_value = fu_value[grant_idx];
    end
  end

  // One holding slot per FU. A bypassed result goes directly to the CDB, so
  // it must not be stored as well; storing it would broadcast it twice.
  for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
    logic              valid_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] value_q;
    logic              bypass;

    assign bypass = grant[g] & ~valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        tag_q   <= '0;
        value_q <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (fu_valid[g] && fu_ready[g] && !bypass) begin
        valid_q <= 1'b1;
        tag_q   <= fu_tag[g];
        value_q <= fu_value[g];
      end else if (grant[g]) begin
        valid_q <= 1'b0;
      end
    end

    assign slot_valid[g] = valid_q;
    assign slot_tag[g]   = tag_q;
    assign slot_value[g] = value_q;
  end

  // Registered broadcast. The payload fields change only on a grant, so they
  // keep their last value while cdb_valid is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_fu    <= '0;
    end else begin
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_tag   <= sel_tag;
        cdb_value <= sel_value;
        cdb_fu    <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter with NUM_FU=4, TAG_W=6, DATA_W=32.
// A reference model tracks, per FU, whether a result is held and which one.
// Each cycle it picks the winner from the arbitration rule (fixed priority,
// or round-robin when CDB_RR_EN is defined) and predicts fu_ready and the
// next CDB broadcast.
// ---------------------------------------------------------------------------

module tb_cdb_arbiter;

  logic              clk;
  logic              reset_n;
  logic              flush;
  logic [3:0]        fu_valid;
  logic [3:0][5:0]   fu_tag;
  logic [3:0][31:0]  fu_value;
  logic [3:0]        fu_ready;
  logic              cdb_valid;
  logic [5:0]        cdb_tag;
  logic [31:0]       cdb_value;
  logic [1:0]        cdb_fu;

  int n_checks;
  int n_errors;

  // Reference model state
  bit          m_held[4];
  logic [5:0]  m_tag[4];
  logic [31:0] m_val[4];
  int          m_ptr;
  logic        m_cdb_valid;
  logic [5:0]  m_cdb_tag;
  logic [31:0] m_cdb_value;
  logic [1:0]  m_cdb_fu;

  logic [3:0][5:0]  rnd_tag;
  logic [3:0][31:0] rnd_val;
  logic [3:0][5:0]  zero_tag;
  logic [3:0][31:0] zero_val;
  logic [1:0]       exp_fu;

  cdb_arbiter #(
    .NUM_FU (4),
    .DATA_W (32),
    .TAG_W  (6)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_value  (fu_value),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_fu    (cdb_fu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so a stuck run still reports instead of hanging
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      m_held[i] = 1'b0;
      m_tag[i]  = '0;
      m_val[i]  = '0;
    end
    m_ptr       = 0;
    m_cdb_valid = 1'b0;
    m_cdb_tag   = '0;
    m_cdb_value = '0;
    m_cdb_fu    = '0;
  endtask

  // Winner = first FU with a held or offered result, in priority order
  function automatic int pickWinner(input logic [3:0] v, input logic fl);
    int idx;
    if (fl) return -1;
    for (int k = 0; k < 4; k++) begin
`ifdef CDB_RR_EN
      idx = (m_ptr + k) % 4;
`else
      idx = k;
`endif
      if (m_held[idx] || v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelStep(input int w, input logic [3:0] rdy, input logic [3:0] v,
                           input logic [3:0][5:0] t, input logic [3:0][31:0] d, input logic fl);
    if (fl) begin
      for (int i = 0; i < 4; i++) m_held[i] = 1'b0;
      m_cdb_valid = 1'b0;
      return;
    end
    if (w >= 0) begin
      m_cdb_valid = 1'b1;
      m_cdb_fu    = 2'(w);
      if (m_held[w]) begin
        m_cdb_tag   = m_tag[w];
        m_cdb_value = m_val[w];
      end else begin
        m_cdb_tag   = t[w];
        m_cdb_value = d[w];
      end
      m_ptr = (w + 1) % 4;
    end else begin
      m_cdb_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (i == w && !m_held[i]) begin
        // sent directly to the bus, nothing stored
      end else if (v[i] && rdy[i]) begin
        m_held[i] = 1'b1;
        m_tag[i]  = t[i];
        m_val[i]  = d[i];
      end else if (i == w) begin
        m_held[i] = 1'b0;
      end
    end
  endtask

  // Runs one cycle. Inputs are driven at the falling edge and fu_ready is
  // checked before the rising edge. The CDB is checked just after it.
  task automatic applyStimulus(input logic [3:0] v, input logic [3:0][5:0] t,
                               input logic [3:0][31:0] d, input logic fl);
    int w;
    logic [3:0] exp_rdy;
    @(negedge clk);
    fu_valid = v;
    fu_tag   = t;
    fu_value = d;
    flush    = fl;
    #1;
    w = pickWinner(v, fl);
    for (int i = 0; i < 4; i++) exp_rdy[i] = !fl && (!m_held[i] || i == w);
    checkOutput("fu_ready", {60'd0, fu_ready}, {60'd0, exp_rdy});
    @(posedge clk);
    modelStep(w, exp_rdy, v, t, d, fl);
    #1;
    checkOutput("cdb_valid", {63'd0, cdb_valid}, {63'd0, m_cdb_valid});
    checkOutput("cdb_tag", {58'd0, cdb_tag}, {58'd0, m_cdb_tag});
    checkOutput("cdb_value", {32'd0, cdb_value}, {32'd0, m_cdb_value});
    checkOutput("cdb_fu", {62'd0, cdb_fu}, {62'd0, m_cdb_fu});
  endtask

  // Pulls reset low between clock edges while every FU is offering. Then
  // checks that the outputs drop at once and releases reset.
  task automatic pulseReset();
    @(negedge clk);
    fu_valid = 4'b1111;
    flush    = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_cdb_valid", {63'd0, cdb_valid}, 64'd0);
    checkOutput("rst_fu_ready", {60'd0, fu_ready}, 64'd0);
    checkOutput("rst_cdb_tag", {58'd0, cdb_tag}, 64'd0);
    checkOutput("rst_cdb_value", {32'd0, cdb_value}, 64'd0);
    checkOutput("rst_cdb_fu", {62'd0, cdb_fu}, 64'd0);
    fu_valid = 4'b0000;
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic randomPayload();
    for (int i = 0; i < 4; i++) begin
      rnd_tag[i] = 6'($urandom);
      rnd_val[i] = $urandom;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    flush    = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_value = '0;
    zero_tag = '0;
    zero_val = '0;
    modelReset();

    // Power-on reset
    pulseReset();

    // Single request: FU0 tag 5 value 0xDEAD shows on the next cycle only
    rnd_tag    = '0;
    rnd_val    = '0;
    rnd_tag[0] = 6'd5;
    rnd_val[0] = 32'hDEAD;
    applyStimulus(4'b0001, rnd_tag, rnd_val, 1'b0);
    checkOutput("single_valid", {63'd0, cdb_valid}, 64'd1);
    checkOutput("single_tag", {58'd0, cdb_tag}, 64'd5);
    checkOutput("single_value", {32'd0, cdb_value}, 64'hDEAD);
    checkOutput("single_fu", {62'd0, cdb_fu}, 64'd0);
    applyStimulus(4'b0000, zero_tag, zero_val, 1'b0);
    checkOutput("single_once", {63'd0, cdb_valid}, 64'd0);

    // All four FUs at once, tags 1..4: broadcast in order 0,1,2,3
    pulseReset();
    for (int i = 0; i < 4; i++) begin
      rnd_tag[i] = 6'(i + 1);
      rnd_val[i] = 32'h1000 + 32'(i);
    end
    applyStimulus(4'b1111, rnd_tag, rnd_val, 1'b0);
    checkOutput("all4_fu0", {62'd0, cdb_fu}, 64'd0);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(4'b0000, zero_tag, zero_val, 1'b0);
      checkOutput("all4_fu", {62'd0, cdb_fu}, 64'(k));
      checkOutput("all4_tag", {58'd0, cdb_tag}, 64'(k + 1));
    end

    // FU0 and FU1 both keep offering: fixed priority starves FU1,
    // round-robin alternates between them
    pulseReset();
    for (int k = 0; k < 6; k++) begin
      randomPayload();
      applyStimulus(4'b0011, rnd_tag, rnd_val, 1'b0);
`ifdef CDB_RR_EN
      exp_fu = 2'(k % 2);
`else
      exp_fu = 2'd0;
`endif
      checkOutput("contend_fu", {62'd0, cdb_fu}, {62'd0, exp_fu});
    end
    applyStimulus(4'b0000, zero_tag, zero_val, 1'b0);
    applyStimulus(4'b0000, zero_tag, zero_val, 1'b0);

    // Pointer wrap: FU2 alone moves the pointer to 3, then FU3 and FU0 compete
    pulseReset();
    randomPayload();
    applyStimulus(4'b0100, rnd_tag, rnd_val, 1'b0);
    randomPayload();
    applyStimulus(4'b1001, rnd_tag, rnd_val, 1'b0);
`ifdef CDB_RR_EN
    exp_fu = 2'd3;
`else
    exp_fu = 2'd0;
`endif
    checkOutput("wrap_first", {62'd0, cdb_fu}, {62'd0, exp_fu});
    applyStimulus(4'b0000, zero_tag, zero_val, 1'b0);
    checkOutput("wrap_second", {62'd0, cdb_fu}, {62'd0, ~exp_fu & 2'b11});

    // Flush with three slots occupied: none of the held tags ever broadcast
    pulseReset();
    randomPayload();
    applyStimulus(4'b1111, rnd_tag, rnd_val, 1'b0);
    applyStimulus(4'b0000, zero_tag, zero_val, 1'b1);
    checkOutput("flush_valid", {63'd0, cdb_valid}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0000, zero_tag, zero_val, 1'b0);
      checkOutput("flush_quiet", {63'd0, cdb_valid}, 64'd0);
    end

    // Random traffic with occasional flushes
    for (int c = 0; c < 300; c++) begin
      randomPayload();
      applyStimulus(4'($urandom_range(0, 15)), rnd_tag, rnd_val, ($urandom_range(0, 19) == 0));
    end

    // Reset in the middle of a burst; nothing comes out afterwards
    for (int c = 0; c < 4; c++) begin
      randomPayload();
      applyStimulus(4'b1111, rnd_tag, rnd_val, 1'b0);
    end
    pulseReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0000, zero_tag, zero_val, 1'b0);
      checkOutput("post_reset_quiet", {63'd0, cdb_valid}, 64'd0);
    end
    randomPayload();
    applyStimulus(4'b0100, rnd_tag, rnd_val, 1'b0);
    checkOutput("post_reset_resume", {63'd0, cdb_valid}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
